// File: rtl/ssd_decoder.sv
// Purpose: debounce an active-low seven-segment pattern and decode it to BCD with an error flag.
// Latency: out_valid rises on the STABLE_CYCLES-th consecutive rising edge that samples the same pattern.
// Backpressure: single-entry output held under out_ready low; a result arriving while full is dropped and sets ovf.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   resetn     synchronous active-low reset
//   hex_in     active-low segments, bit 6 = g ... bit 0 = a
//   out_ready  downstream accepts the held result when high
//   out_valid  out_digit/out_err hold an unconsumed result
//   out_digit  decoded BCD value, 4'hE on an error pattern
//   out_err    qualified pattern was neither a digit nor blank
//   ovf        sticky: a qualified result was dropped because the output was full
module ssd_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] hex_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_err,
    output logic       ovf
);

    localparam logic [6:0] BLANK    = 7'h7F;
    localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] QUAL_CNT = 4'(STABLE_CYCLES - 2);

    logic [6:0] prev;
    logic [3:0] cnt;
    logic [6:0] last_emitted;

    logic [3:0] dec_digit;
    logic       dec_err;

    logic same;
    logic qual;
    logic new_pat;
    logic produce;
    logic load;

    always_comb begin
        dec_digit = 4'hE;
        dec_err   = 1'b1;
        case (hex_in)
            7'h40: begin dec_digit = 4'd0; dec_err = 1'b0; end
            7'h79: begin dec_digit = 4'd1; dec_err = 1'b0; end
            7'h24: begin dec_digit = 4'd2; dec_err = 1'b0; end
            7'h30: begin dec_digit = 4'd3; dec_err = 1'b0; end
            7'h19: begin dec_digit = 4'd4; dec_err = 1'b0; end
            7'h12: begin dec_digit = 4'd5; dec_err = 1'b0; end
            7'h02: begin dec_digit = 4'd6; dec_err = 1'b0; end
            7'h78: begin dec_digit = 4'd7; dec_err = 1'b0; end
            7'h00: begin dec_digit = 4'd8; dec_err = 1'b0; end
            7'h18: begin dec_digit = 4'd9; dec_err = 1'b0; end
            default: begin dec_digit = 4'hE; dec_err = 1'b1; end
        endcase
    end

    // cnt saturates at CNT_MAX, so cnt == QUAL_CNT can only be seen once
    // per unbroken run of the same pattern: qualification is one-shot.
    always_comb begin
        same    = (hex_in == prev);
        qual    = same && (cnt == QUAL_CNT);
        new_pat = qual && (hex_in != last_emitted);
        produce = new_pat && (hex_in != BLANK);
        load    = produce && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev         <= BLANK;
            cnt          <= 4'd0;
            last_emitted <= BLANK;
            out_valid    <= 1'b0;
            out_digit    <= 4'd0;
            out_err      <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            prev <= hex_in;
            if (!same)
                cnt <= 4'd0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 4'd1;

            // A dropped result still updates last_emitted so the same
            // held pattern is not re-offered once the output drains.
            if (new_pat)
                last_emitted <= hex_in;

            if (load) begin
                out_valid <= 1'b1;
                out_digit <= dec_digit;
                out_err   <= dec_err;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (produce && !load)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ssd_decoder.sv
// Purpose: self-checking bench for ssd_decoder against a run-length reference model.
// Latency: one check set per clock edge, sampled 1 time unit after the rising edge.
// Backpressure: out_ready driven directly by the stimulus, directed and random.
module tb_ssd_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] hex_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_err;
    logic       ovf;

    ssd_decoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .hex_in    (hex_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_err   (out_err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int vcount = 0;

    // Reference model: run length of identical samples, single output slot.
    logic [6:0] m_last_sample;
    int         m_run;
    logic [6:0] m_last_em;
    logic       m_valid;
    logic [3:0] m_digit;
    logic       m_err;
    logic       m_ovf;

    logic [6:0] legal [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_sample = 7'h7F;
        m_run         = 1;
        m_last_em     = 7'h7F;
        m_valid       = 1'b0;
        m_digit       = 4'd0;
        m_err         = 1'b0;
        m_ovf         = 1'b0;
    endtask

    task automatic model_edge(input logic [6:0] h, input logic r);
        logic [3:0] d;
        logic       e;
        logic       xfer;
        logic       prod;
        xfer = m_valid && r;
        prod = 1'b0;
        if (h == m_last_sample) m_run++;
        else                    m_run = 1;
        m_last_sample = h;
        if (m_run == S && h != m_last_em) begin
            m_last_em = h;
            prod = (h != 7'h7F);
        end
        d = 4'hE;
        e = 1'b1;
        for (int i = 0; i < 10; i++)
            if (legal[i] == h) begin
                d = 4'(i);
                e = 1'b0;
            end
        if (prod) begin
            if (!m_valid || r) begin
                m_valid = 1'b1;
                m_digit = d;
                m_err   = e;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, m_valid});
        chk({tag, ".digit"}, {4'd0, out_digit}, {4'd0, m_digit});
        chk({tag, ".err"},   {7'd0, out_err},   {7'd0, m_err});
        chk({tag, ".ovf"},   {7'd0, ovf},       {7'd0, m_ovf});
        if (out_valid) vcount++;
    endtask

    task automatic step(input logic [6:0] h, input logic r, input string tag);
        resetn    = 1'b1;
        hex_in    = h;
        out_ready = r;
        @(posedge clk);
        model_edge(h, r);
        #1;
        compare_all(tag);
    endtask

    task automatic hold(input logic [6:0] h, input logic r, input int n, input string tag);
        for (int i = 0; i < n; i++) step(h, r, tag);
    endtask

    task automatic do_reset(input logic [6:0] h, input string tag);
        resetn    = 1'b0;
        hex_in    = h;
        out_ready = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [6:0] h;
        int         n;
        int         v0;

        resetn    = 1'b0;
        hex_in    = 7'h7F;
        out_ready = 1'b1;
        #2;
        do_reset(7'h7F, "reset");
        hold(7'h7F, 1'b1, 3, "idle_blank");

        // Digit 2 appears on exactly the 4th edge, for one cycle.
        hold(7'h24, 1'b1, 3, "lat_pre");
        chk("lat_not_early", {7'd0, out_valid}, 8'd0);
        step(7'h24, 1'b1, "lat_edge4");
        chk("lat_valid", {7'd0, out_valid}, 8'd1);
        chk("lat_digit", {4'd0, out_digit}, 8'd2);
        step(7'h24, 1'b1, "lat_after");
        chk("lat_one_cycle", {7'd0, out_valid}, 8'd0);

        // A short-lived pattern never qualifies.
        hold(7'h30, 1'b1, 3, "glitch");
        hold(7'h12, 1'b1, 4, "five");
        chk("five_digit", {4'd0, out_digit}, 8'd5);
        hold(7'h12, 1'b1, 2, "five_tail");

        // Backpressure: 1 is held, 8 is dropped and flagged.
        hold(7'h79, 1'b0, 4, "bp_one");
        hold(7'h00, 1'b0, 5, "bp_eight");
        chk("bp_ovf", {7'd0, ovf}, 8'd1);
        chk("bp_held_digit", {4'd0, out_digit}, 8'd1);
        step(7'h00, 1'b1, "bp_xfer");
        v0 = vcount;
        hold(7'h00, 1'b1, 6, "bp_no_eight");
        chk("bp_eight_never", 8'(vcount - v0), 8'd0);

        // Blank re-arms a repeat of the same digit.
        v0 = vcount;
        hold(7'h19, 1'b1, 5, "rep_a");
        hold(7'h7F, 1'b1, 5, "rep_blank");
        hold(7'h19, 1'b1, 5, "rep_b");
        hold(7'h19, 1'b1, 8, "rep_hold");
        chk("rep_count", 8'(vcount - v0), 8'd2);

        // Error pattern.
        hold(7'h55, 1'b1, 4, "err");
        chk("err_flag", {7'd0, out_err}, 8'd1);
        chk("err_digit", {4'd0, out_digit}, 8'hE);
        step(7'h55, 1'b1, "err_tail");

        // Reset discards a held output and clears ovf.
        hold(7'h24, 1'b0, 4, "rst_fill");
        hold(7'h30, 1'b0, 4, "rst_drop");
        chk("rst_pre_ovf", {7'd0, ovf}, 8'd1);
        do_reset(7'h30, "rst_edge");
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_ovf", {7'd0, ovf}, 8'd0);
        hold(7'h30, 1'b1, 3, "rst_reemit_pre");
        step(7'h30, 1'b1, "rst_reemit");
        chk("rst_reemit_valid", {7'd0, out_valid}, 8'd1);
        chk("rst_reemit_digit", {4'd0, out_digit}, 8'd3);

        // Random runs: digits, blank and arbitrary codes, random hold and ready.
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 3))
                0, 1: h = legal[$urandom_range(0, 9)];
                2:    h = 7'h7F;
                default: h = 7'($urandom);
            endcase
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++)
                step(h, ($urandom_range(0, 3) != 0), "rand");
            if ($urandom_range(0, 39) == 0)
                do_reset(h, "rand_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssd_decoder.md
SSD_DECODER -- requirements
Module: ssd_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive rising edges a segment pattern must be sampled unchanged before it is decoded; legal range 2..16.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port: hex_in  input  7  active-low seven-segment pattern, bit 6 = segment g ... bit 0 = segment a.
REQ-005 Port: out_ready  input  1  downstream accepts the current output when high.
REQ-006 Port: out_valid  output  1  out_digit/out_err hold a decoded, unconsumed result.
REQ-007 Port: out_digit  output  4  decoded BCD value; 4'hE when out_err is high.
REQ-008 Port: out_err  output  1  the qualified pattern is not a legal digit or blank.
REQ-009 Port: ovf  output  1  sticky flag: a qualified result was dropped because the output was full.

Function
REQ-010 Legal patterns (hex_in) SHALL decode as: 7'h40->0, 7'h79->1, 7'h24->2, 7'h30->3, 7'h19->4, 7'h12->5, 7'h02->6, 7'h78->7, 7'h00->8, 7'h18->9; 7'h7F is blank; every other value is an error pattern.
REQ-011 Register prev SHALL load hex_in every edge; a 4-bit counter cnt SHALL clear to 0 when hex_in != prev, else increment, saturating at STABLE_CYCLES-1.
REQ-012 A qualification event SHALL occur on the edge where hex_in == prev and cnt == STABLE_CYCLES-2 (one-shot per stable run), i.e. on the STABLE_CYCLES-th consecutive edge sampling the same pattern.
REQ-013 On a qualification event, if the pattern equals last_emitted, nothing SHALL happen.
REQ-014 On a qualification event of blank, last_emitted SHALL load 7'h7F and no result SHALL be produced.
REQ-015 On a qualification event of a digit or error pattern different from last_emitted, last_emitted SHALL load the pattern and a result SHALL be produced.
REQ-016 A produced result SHALL load out_digit/out_err and set out_valid on that same edge when out_valid is low or out_ready is high.
REQ-017 A produced result arriving while out_valid is high and out_ready is low SHALL be dropped, ovf SHALL set, and the held output SHALL remain unchanged.
REQ-018 Handshake: transfer occurs on an edge with out_valid and out_ready both high; out_valid SHALL then clear unless REQ-016 loads a new result on the same edge, in which case out_valid stays high with the new data.
REQ-019 out_digit, out_err SHALL be stable while out_valid is high and out_ready is low.
REQ-020 Latency: a new legal pattern applied and held SHALL produce out_valid high after exactly STABLE_CYCLES rising edges.
REQ-021 A pattern changing before qualification SHALL produce no output and no error.
REQ-022 ovf SHALL be cleared only by reset.

Reset
REQ-023 With resetn low at a rising edge: out_valid=0, out_digit=0, out_err=0, ovf=0, cnt=0, prev=7'h7F, last_emitted=7'h7F.
REQ-024 Reset SHALL take priority over every other event, including a pending transfer or a qualification on the same edge; a held output SHALL be discarded.

Verification
REQ-025 STABLE_CYCLES=4, out_ready=1, hex_in 7'h7F -> 7'h24 held -> out_valid high after the 4th edge, out_digit=2, out_err=0, for one cycle only.
REQ-026 hex_in 7'h30 for 3 edges then 7'h12 held -> no output for 3; out_digit=5 after the 4th edge of 7'h12.
REQ-027 out_ready=0; 7'h79 held, then 7'h00 held -> out_digit=1 held, ovf=1; raising out_ready -> one transfer of 1, the 8 is never emitted.
REQ-028 7'h19 held, 7'h7F held, 7'h19 held (out_ready=1) -> two results of 4, none for blank; 7'h19 held continuously -> exactly one result.
REQ-029 hex_in 7'h55 held -> out_valid=1, out_err=1, out_digit=4'hE.
REQ-030 resetn low for one edge while out_valid=1 and ovf=1 -> all outputs 0 after that edge; the same pattern held afterward re-emits after 4 edges.
